// File: rtl/main_fsm_if.sv
// Control-path bundle between the multicycle main FSM and its datapath.
// The FSM is the master: it consumes the decoded instruction fields and drives every control line.
interface main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic [3:0] State;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               NextPC, RegW, MemW, Branch, ALUOp, State
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               NextPC, RegW, MemW, Branch, ALUOp, State
    );
endinterface

// File: rtl/main_fsm.sv
// Moore main controller for a multicycle ARM-style datapath.
// Registered state; every control output is decoded from the state alone.
module main_fsm (
    input  logic          clk,
    input  logic          reset,
    main_fsm_if.master    bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t state, state_next;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Op/Funct are only looked at in DECODE and MEMADR; all other states advance unconditionally.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR:   state_next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    // NOTE: every output gets a zero default first, so no path leaves a latch behind.
    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.ALUOp     = 1'b0;
        case (state)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.NextPC    = 1'b1;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR: begin
                bus.ALUSrcB   = 2'b01;
            end
            MEMRD: begin
                bus.AdrSrc    = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegW      = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc    = 1'b1;
                bus.MemW      = 1'b1;
            end
            EXECUTER: begin
                bus.ALUOp     = 1'b1;
            end
            EXECUTEI: begin
                bus.ALUSrcB   = 2'b01;
                bus.ALUOp     = 1'b1;
            end
            ALUWB: begin
                bus.RegW      = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.Branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.State = state;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: walks each instruction class state by state and checks
// State plus the full control word against hand-derived values.
module tb_main_fsm;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    main_fsm_if bus ();

    main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control word order: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC RegW MemW Branch ALUOp
    logic [12:0] ctl;
    assign ctl = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                  bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp};

    localparam logic [12:0] C_FETCH  = 13'b1_0_01_10_10_1_0_0_0_0;
    localparam logic [12:0] C_DECODE = 13'b0_0_01_10_10_0_0_0_0_0;
    localparam logic [12:0] C_MEMADR = 13'b0_0_00_01_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMRD  = 13'b0_1_00_00_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMWB  = 13'b0_0_00_00_01_0_1_0_0_0;
    localparam logic [12:0] C_MEMWR  = 13'b0_1_00_00_00_0_0_1_0_0;
    localparam logic [12:0] C_EXECR  = 13'b0_0_00_00_00_0_0_0_0_1;
    localparam logic [12:0] C_EXECI  = 13'b0_0_00_01_00_0_0_0_0_1;
    localparam logic [12:0] C_ALUWB  = 13'b0_0_00_00_00_0_1_0_0_0;
    localparam logic [12:0] C_BRANCH = 13'b0_0_00_01_10_0_0_0_1_0;
    localparam logic [12:0] C_UNK    = 13'b0_0_00_00_00_0_0_0_0_0;

    task automatic test_reset();
        reset    = 1'b1;
        bus.Op    = 2'b00;
        bus.Funct = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.State !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", bus.State);
        end
        checks++;
        if (ctl !== C_FETCH) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, C_FETCH);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_dp_reg();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        logic [12:0] ct [5] = '{C_FETCH, C_DECODE, C_EXECR, C_ALUWB, C_FETCH};
        bus.Op = 2'b00; bus.Funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.State !== st[i]) begin
                errors++;
                $display("FAIL dp_reg_state[%0d]: got %0d expected %0d", i, bus.State, st[i]);
            end
            checks++;
            if (ctl !== ct[i]) begin
                errors++;
                $display("FAIL dp_reg_ctl[%0d]: got %b expected %b", i, ctl, ct[i]);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_ldr();
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [12:0] ct [6] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
        bus.Op = 2'b01; bus.Funct = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.State !== st[i]) begin
                errors++;
                $display("FAIL ldr_state[%0d]: got %0d expected %0d", i, bus.State, st[i]);
            end
            checks++;
            if (ctl !== ct[i]) begin
                errors++;
                $display("FAIL ldr_ctl[%0d]: got %b expected %b", i, ctl, ct[i]);
            end
            if (i < 5) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_str();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        logic [12:0] ct [5] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH};
        bus.Op = 2'b01; bus.Funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.State !== st[i]) begin
                errors++;
                $display("FAIL str_state[%0d]: got %0d expected %0d", i, bus.State, st[i]);
            end
            checks++;
            if (ctl !== ct[i]) begin
                errors++;
                $display("FAIL str_ctl[%0d]: got %b expected %b", i, ctl, ct[i]);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_branch_illegal();
        logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd0};
        logic [12:0] ct [7] = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_DECODE, C_UNK, C_FETCH};
        bus.Op = 2'b10; bus.Funct = 6'b111111;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) bus.Op = 2'b11;
            checks++;
            if (bus.State !== st[i]) begin
                errors++;
                $display("FAIL br_ill_state[%0d]: got %0d expected %0d", i, bus.State, st[i]);
            end
            checks++;
            if (ctl !== ct[i]) begin
                errors++;
                $display("FAIL br_ill_ctl[%0d]: got %b expected %b", i, ctl, ct[i]);
            end
            if (i < 6) begin @(posedge clk); #1; end
        end
    endtask

    // Op/Funct are scrambled outside DECODE/MEMADR; the STR path must be unaffected.
    task automatic test_input_ignore();
        logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        bus.Op = 2'b01; bus.Funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.State !== st[i]) begin
                errors++;
                $display("FAIL ignore_state[%0d]: got %0d expected %0d", i, bus.State, st[i]);
            end
            if (i < 4) begin
                @(posedge clk); #1;
                if (i == 2) begin bus.Op = 2'b11; bus.Funct = 6'b111111; end
            end
        end
        // Back in FETCH with garbage inputs: FETCH still goes to DECODE
        @(posedge clk); #1;
        checks++;
        if (bus.State !== 4'd1) begin
            errors++;
            $display("FAIL ignore_fetch_next: got %0d expected 1", bus.State);
        end
        // DECODE with Op=11 lands in UNKNOWN, then FETCH
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.State !== 4'd0) begin
            errors++;
            $display("FAIL ignore_return: got %0d expected 0", bus.State);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        logic [12:0] ct [5] = '{C_FETCH, C_DECODE, C_EXECI, C_ALUWB, C_FETCH};
        bus.Op = 2'b01; bus.Funct = 6'b000001;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.State !== 4'd3) begin
            errors++;
            $display("FAIL async_pre_state: got %0d expected 3", bus.State);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.State !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_state: got %0d expected 0", bus.State);
        end
        checks++;
        if (ctl !== C_FETCH) begin
            errors++;
            $display("FAIL async_reset_ctl: got %b expected %b", ctl, C_FETCH);
        end
        @(posedge clk);
        bus.Op = 2'b00; bus.Funct = 6'b100000;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.State !== st[i]) begin
                errors++;
                $display("FAIL async_after_state[%0d]: got %0d expected %0d", i, bus.State, st[i]);
            end
            checks++;
            if (ctl !== ct[i]) begin
                errors++;
                $display("FAIL async_after_ctl[%0d]: got %b expected %b", i, ctl, ct[i]);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_dp_reg();
        test_ldr();
        test_str();
        test_branch_illegal();
        test_input_ignore();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have parameter-free ports; state encoding is fixed by REQ-016.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
REQ-004 Op  input  2  instruction class from IR[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-005 Funct  input  6  IR[25:20]; bit 5 = immediate (I), bit 0 = load (L) / set-flags (S).
REQ-006 IRWrite  output  1  load instruction register.
REQ-007 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 ALUSrcA  output  2  ALU A select: 00 = register A, 01 = PC.
REQ-009 ALUSrcB  output  2  ALU B select: 00 = register B, 01 = extended immediate, 10 = constant 4.
REQ-010 ResultSrc  output  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-011 NextPC  output  1  request PC update with PC+4 (unconditional).
REQ-012 RegW  output  1  register-write request, pre-condition-gating.
REQ-013 MemW  output  1  memory-write request, pre-condition-gating.
REQ-014 Branch  output  1  branch-target PC write request, pre-condition-gating.
REQ-015 ALUOp  output  1  1 = ALU decoder uses Funct; 0 = ALU adds.
REQ-016 State  output  4  current state: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, UNKNOWN 10.

Function
REQ-017 SHALL be a Moore machine: every output is a function of State only, registered state, combinational outputs.
REQ-018 Any output not listed as set in a state SHALL be 0 in that state (no don't-cares).
REQ-019 FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0; next DECODE.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; next by Op/Funct per REQ-021.
REQ-021 DECODE transitions: Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
REQ-022 MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0; next MEMRD if Funct[0]=1, else MEMWR.
REQ-023 MEMRD: AdrSrc=1, ResultSrc=00; next MEMWB.
REQ-024 MEMWB: ResultSrc=01, RegW=1; next FETCH.
REQ-025 MEMWR: AdrSrc=1, ResultSrc=00, MemW=1; next FETCH.
REQ-026 EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1; next ALUWB.
REQ-027 EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1; next ALUWB.
REQ-028 ALUWB: ResultSrc=00, RegW=1; next FETCH.
REQ-029 BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1; next FETCH.
REQ-030 UNKNOWN: all outputs 0; next FETCH (illegal instruction is a 3-cycle no-op).
REQ-031 Unencoded State values 11-15 SHALL transition to FETCH next cycle with all outputs 0.
REQ-032 Instruction latency in cycles SHALL be: LDR 5, STR 4, data-processing 4, branch 3, illegal 3.
REQ-033 RegW/MemW/Branch SHALL assert exactly one cycle per instruction, in the cycle after the state in which ALUOp or flag-producing computation occurs, so the downstream one-cycle-latched condition applies.
REQ-034 Op/Funct SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-035 While reset=1: State=FETCH, outputs per FETCH (IRWrite=1, NextPC=1); downstream write enables are gated by reset elsewhere.
REQ-036 Reset asserted mid-instruction SHALL abandon it; first rising edge after deassertion SHALL move FETCH -> DECODE.

Verification
REQ-037 Reset release, Op=00 Funct=000000 -> State 0,1,6,8,0; RegW=1 only in state 8, ALUOp=1 only in state 6.
REQ-038 Op=01 Funct=000001 -> States 0,1,2,3,4,0; AdrSrc=1 in 3; ResultSrc=01 and RegW=1 in 4.
REQ-039 Op=01 Funct=000000 -> States 0,1,2,5,0; MemW=1 only in 5; RegW never 1.
REQ-040 Op=10 -> States 0,1,9,0; Branch=1 with ALUSrcB=01 in 9; Op=11 -> 0,1,10,0 with all outputs 0 in 10.
REQ-041 Assert reset asynchronously during MEMRD (between edges) -> State=0 before next edge; Op=00 Funct=100000 after release -> States 0,1,7,8.
